flag_gate_array: RTL and testbench

Parametrised, multi-channel successor to the single-bit gated flag register. Each channel inverts its input slice, forms a masked reduce-OR enable term, and gates it with a registered arm flag. The arm flag has an optional sticky mode, per-channel clear, a post-deassert hold window, and a saturating arm-event counter. It sits between the stimulus input bus and the flag outputs of the equivalence-test harness.

---
 rtl/flag_gate_pkg.sv | 18 +
 rtl/flag_gate_lane.sv | 92 +++++++++
 rtl/flag_gate_array.sv | 48 ++++
 tb/tb_flag_gate_array.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/flag_gate_pkg.sv
// flag_gate_pkg
// Constants and helpers used by the flag gate array and its per-channel lanes.
//   EV_W       : width of each per-channel arm-event counter
//   hold_cnt_w : width of the hold-window counter for a given HOLD length
package flag_gate_pkg;

    localparam int EV_W = 8;

    // A zero-length hold still needs a 1-bit vector to declare; that bit
    // is tied to zero inside the lane.
    function automatic int hold_cnt_w(input int hold);
        if (hold < 1) begin
            return 1;
        end
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/flag_gate_lane.sv
// flag_gate_lane
// One channel of the flag gate array: inverts its input slice, forms the
// masked reduce-OR term, and gates it with a registered arm flag plus a
// post-disarm hold window. Also counts arm rising edges (saturating).
// Ports:
//   clk_i     : clock, all state updates on the rising edge
//   srst_i    : synchronous active-high reset
//   slice_i   : W-bit input slice for this channel
//   en_i      : arm-update enable
//   clr_i     : synchronous clear of the arm flag (does not touch the counter)
//   flag_o    : gated flag output
//   ev_cnt_o  : saturating count of arm rising edges
module flag_gate_lane
    import flag_gate_pkg::*;
#(
    parameter int             W      = 2,
    parameter logic [W-1:0]   MASK   = '0,
    parameter int             HOLD   = 3,
    parameter int             STICKY = 0
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [W-1:0]      slice_i,
    input  logic              en_i,
    input  logic              clr_i,
    output logic              flag_o,
    output logic [EV_W-1:0]   ev_cnt_o
);

    localparam int            HW     = hold_cnt_w(HOLD);
    localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

    logic [W-1:0]    inv;
    logic            comb;
    logic            arm_q,  arm_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [EV_W-1:0] ev_q,   ev_d;

    assign inv  = ~slice_i;
    assign comb = |(inv | MASK);

    // Arm flag: clear beats enable; sticky mode only ever sets bits.
    always_comb begin
        arm_d = arm_q;
        if (clr_i) begin
            arm_d = 1'b0;
        end else if (en_i) begin
            if (STICKY != 0) begin
                arm_d = arm_q | inv[0];
            end else begin
                arm_d = inv[0];
            end
        end
    end

    // Hold window: reloaded every armed cycle, so it starts counting down
    // from HOLD in the first cycle after the arm flag drops.
    always_comb begin
        hold_d = hold_q;
        if (HOLD == 0) begin
            hold_d = '0;
        end else if (arm_q) begin
            hold_d = HOLD_V;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    // Rising edge of the arm flag, saturating at all-ones.
    always_comb begin
        ev_d = ev_q;
        if (arm_d && !arm_q && (ev_q != '1)) begin
            ev_d = ev_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            arm_q  <= 1'b0;
            hold_q <= '0;
            ev_q   <= '0;
        end else begin
            arm_q  <= arm_d;
            hold_q <= hold_d;
            ev_q   <= ev_d;
        end
    end

    assign flag_o   = (arm_q || (hold_q != '0)) ? 1'b0 : comb;
    assign ev_cnt_o = ev_q;

endmodule

// File: rtl/flag_gate_array.sv
// flag_gate_array
// CH independent gated-flag channels sharing a clock, reset and arm enable.
// Ports:
//   clock_10 : clock, all state updates on the rising edge
//   clock_12 : synchronous active-high reset
//   in5      : CH input slices of W bits; channel c = in5[c*W +: W]
//   en       : arm-update enable shared by all channels
//   clr      : per-channel synchronous clear of the arm flag
//   out18    : gated flag per channel
//   ev_cnt   : per-channel saturating arm-event counts; channel c = ev_cnt[c*8 +: 8]
module flag_gate_array
    import flag_gate_pkg::*;
#(
    parameter int           CH     = 4,
    parameter int           W      = 2,
    parameter logic [W-1:0] MASK   = '0,
    parameter int           HOLD   = 3,
    parameter int           STICKY = 0
) (
    input  logic                 clock_10,
    input  logic                 clock_12,
    input  logic [CH*W-1:0]      in5,
    input  logic                 en,
    input  logic [CH-1:0]        clr,
    output logic [CH-1:0]        out18,
    output logic [CH*EV_W-1:0]   ev_cnt
);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_lane
            flag_gate_lane #(
                .W      (W),
                .MASK   (MASK),
                .HOLD   (HOLD),
                .STICKY (STICKY)
            ) u_lane (
                .clk_i    (clock_10),
                .srst_i   (clock_12),
                .slice_i  (in5[gi*W +: W]),
                .en_i     (en),
                .clr_i    (clr[gi]),
                .flag_o   (out18[gi]),
                .ev_cnt_o (ev_cnt[gi*EV_W +: EV_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_flag_gate_array.sv
module tb_flag_gate_array;

    localparam int CH  = 4;
    localparam int W   = 2;
    localparam int NI  = 3;
    localparam int BIG = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in5;
    logic        en;
    logic [3:0]  clr;
    logic [3:0]  out_b, out_s, out_m;
    logic [31:0] ev_b, ev_s, ev_m;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Three builds: plain, sticky, and masked with no hold window.
    int         cfg_sticky [NI] = '{0, 1, 0};
    int         cfg_hold   [NI] = '{3, 3, 0};
    logic [1:0] cfg_mask   [NI] = '{2'b00, 2'b00, 2'b01};

    // Reference state: arm flag, cycles elapsed since it last fell, event count.
    int m_arm   [NI][CH];
    int m_since [NI][CH];
    int m_cnt   [NI][CH];

    always #5 clk = ~clk;

    flag_gate_array dut_b (
        .clock_10 (clk), .clock_12 (rst), .in5 (in5), .en (en), .clr (clr),
        .out18 (out_b), .ev_cnt (ev_b)
    );

    flag_gate_array #(.STICKY(1)) dut_s (
        .clock_10 (clk), .clock_12 (rst), .in5 (in5), .en (en), .clr (clr),
        .out18 (out_s), .ev_cnt (ev_s)
    );

    flag_gate_array #(.MASK(2'b01), .HOLD(0)) dut_m (
        .clock_10 (clk), .clock_12 (rst), .in5 (in5), .en (en), .clr (clr),
        .out18 (out_m), .ev_cnt (ev_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_out(input int i);
        logic [3:0] r;
        logic [1:0] inv;
        logic       comb;
        for (int c = 0; c < CH; c++) begin
            inv  = ~in5[c*W +: W];
            comb = |(inv | cfg_mask[i]);
            if (m_arm[i][c] != 0 || m_since[i][c] < cfg_hold[i]) r[c] = 1'b0;
            else r[c] = comb;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_ev(input int i);
        logic [31:0] r;
        for (int c = 0; c < CH; c++) r[c*8 +: 8] = 8'(m_cnt[i][c]);
        return r;
    endfunction

    task automatic model_clock();
        int nxt;
        int inv0;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (rst) begin
                    m_arm[i][c]   = 0;
                    m_since[i][c] = BIG;
                    m_cnt[i][c]   = 0;
                end else begin
                    inv0 = in5[c*W] ? 0 : 1;
                    if (clr[c]) nxt = 0;
                    else if (en && cfg_sticky[i] != 0) nxt = (m_arm[i][c] != 0 || inv0 != 0) ? 1 : 0;
                    else if (en) nxt = inv0;
                    else nxt = m_arm[i][c];
                    if (nxt == 1 && m_arm[i][c] == 0 && m_cnt[i][c] < 255) m_cnt[i][c]++;
                    if (m_arm[i][c] != 0) m_since[i][c] = 0;
                    else if (m_since[i][c] < BIG) m_since[i][c]++;
                    m_arm[i][c] = nxt;
                end
            end
        end
    endtask

    // One transaction: drive on the falling edge, compare just after, then
    // advance the reference on the rising edge.
    task automatic cycle(input logic r, input logic [7:0] d, input logic e,
                         input logic [3:0] c, input bit do_check);
        @(negedge clk);
        rst = r; in5 = d; en = e; clr = c;
        #1;
        $display("cyc=%0d rst=%0b in5=%02h en=%0b clr=%01h out=%01h/%01h/%01h ev=%08h/%08h/%08h",
                 cyc, r, d, e, c, out_b, out_s, out_m, ev_b, ev_s, ev_m);
        if (do_check) begin
            check("out_base",   {28'd0, out_b}, {28'd0, exp_out(0)});
            check("out_sticky", {28'd0, out_s}, {28'd0, exp_out(1)});
            check("out_mask",   {28'd0, out_m}, {28'd0, exp_out(2)});
            check("ev_base",    ev_b, exp_ev(0));
            check("ev_sticky",  ev_s, exp_ev(1));
            check("ev_mask",    ev_m, exp_ev(2));
        end
        @(posedge clk);
        model_clock();
        cyc++;
    endtask

    initial begin
        logic [7:0] sat_before;
        rst = 1'b1; in5 = 8'h00; en = 1'b0; clr = 4'h0;
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < CH; c++) begin
                m_arm[i][c] = 0; m_since[i][c] = BIG; m_cnt[i][c] = 0;
            end

        // Reset with all-zero input: comb is all ones.
        cycle(1'b1, 8'h00, 1'b0, 4'h0, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 4'h0, 1'b1);
        #1;
        check("rst_out_const", {28'd0, out_b}, 32'h0000_000F);
        check("rst_ev_const",  ev_b, 32'h0);
        cycle(1'b0, 8'hFF, 1'b0, 4'h0, 1'b1);
        #1;
        check("ff_unarmed_base", {28'd0, out_b}, 32'h0);
        check("ff_unarmed_mask", {28'd0, out_m}, 32'h0000_000F);

        // Arm channel 0, then drop it and watch the hold window.
        cycle(1'b0, 8'hFE, 1'b1, 4'h0, 1'b1);
        #1;
        check("arm_ch0_ev", {24'd0, ev_b[7:0]}, 32'd1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 8'hFD, 1'b1, 4'h0, 1'b1);

        // Sticky on channel 1: arm, hold with inv[0]=0, then clear while setting.
        cycle(1'b0, 8'hFB, 1'b1, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'hFF, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 8'hFB, 1'b1, 4'h2, 1'b1);
        cycle(1'b0, 8'hFF, 1'b1, 4'h0, 1'b1);
        #1;
        check("sticky_clr_ev1", {24'd0, ev_s[15:8]}, 32'd1);

        // Saturation on channel 2: 300 arm rising edges.
        for (int k = 0; k < 300; k++) begin
            cycle(1'b0, 8'hEF, 1'b1, 4'h0, 1'b1);
            cycle(1'b0, 8'hFF, 1'b1, 4'h4, 1'b1);
        end
        #1;
        check("sat_ev2_base",   {24'd0, ev_b[23:16]}, 32'hFF);
        check("sat_ev2_sticky", {24'd0, ev_s[23:16]}, 32'hFF);
        sat_before = ev_b[23:16];
        cycle(1'b0, 8'hEF, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 8'hFF, 1'b1, 4'h0, 1'b1);
        #1;
        check("sat_ev2_stays", {24'd0, ev_b[23:16]}, {24'd0, sat_before});

        // Reset in the middle of a hold window.
        cycle(1'b0, 8'hFE, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 8'hFD, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 8'hFD, 1'b1, 4'h0, 1'b1);
        cycle(1'b1, 8'hFD, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
        #1;
        check("midhold_rst_out", {28'd0, out_b}, 32'h0000_000F);
        check("midhold_rst_ev",  ev_b, 32'h0);

        // Enable low: arm never changes whatever the input.
        for (int k = 0; k < 10; k++) cycle(1'b0, 8'($urandom), 1'b0, 4'h0, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            cycle(($urandom_range(0, 99) == 0), 8'($urandom), 1'($urandom),
                  4'($urandom & $urandom & $urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
